// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: load-use interlock, fixed-latency div/mod
// occupancy of EX, branch and exception flushes, and a stall-cycle counter.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 17
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        ex_valid,
  input  logic        ex_fire,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_div,
  input  logic [4:0]  id_rj,
  input  logic [4:0]  id_rk,
  input  logic        ex_br_redirect,
  input  logic        wb_exc,
  output logic        if_ready_go,
  output logic        id_ready_go,
  output logic        ex_ready_go,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_DIV = 2'd1,
    ST_EXC = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_div_done;
  logic        w_div_done_nxt;
  logic [31:0] r_stall_cnt;

  logic        w_load_use;
  logic        w_div_start;
  logic        w_cnt_zero;
  logic        w_stall;

  assign w_load_use  = ex_valid && ex_load && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rj) || (ex_rd == id_rk));
  assign w_div_start = ex_valid && ex_div && !r_div_done;
  assign w_cnt_zero  = (r_cnt == 8'd0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_RUN;
      r_cnt      <= 8'd0;
      r_div_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_done <= w_div_done_nxt;
    end
  end

  // An exception overrides everything else, so it is applied last.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_done_nxt = r_div_done;
    if (ex_fire) begin
      w_div_done_nxt = 1'b0;
    end
    case (r_state)
      ST_RUN: begin
        if (w_div_start) begin
          w_state_nxt = ST_DIV;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_DIV: begin
        if (w_cnt_zero) begin
          w_state_nxt    = ST_RUN;
          w_div_done_nxt = !ex_fire;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_EXC: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    if (wb_exc) begin
      w_state_nxt    = ST_EXC;
      w_cnt_nxt      = 8'd0;
      w_div_done_nxt = 1'b0;
    end
  end

  // Reset must present a fully flushed, free-running pipeline without a clock.
  always_comb begin
    if_ready_go = 1'b1;
    id_ready_go = 1'b1;
    ex_ready_go = 1'b1;
    if_flush    = 1'b1;
    id_flush    = 1'b1;
    ex_flush    = 1'b1;
    mem_flush   = 1'b1;
    if (aresetn) begin
      if_ready_go = (r_state != ST_EXC);
      id_ready_go = !w_load_use;
      ex_ready_go = (r_state != ST_DIV) || w_cnt_zero;
      if_flush    = wb_exc || ex_br_redirect;
      id_flush    = wb_exc || ex_br_redirect;
      ex_flush    = wb_exc;
      mem_flush   = wb_exc;
    end
  end

  assign w_stall = (!id_ready_go || !ex_ready_go) && !wb_exc;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues hand-computed expectations,
// a monitor samples the DUT after each falling edge and compares them.
module tb_pipe_ctrl;

  localparam int SEL_STATE = 0;
  localparam int SEL_STALL = 1;
  localparam int SEL_IFRDY = 2;
  localparam int SEL_IDRDY = 3;
  localparam int SEL_EXRDY = 4;
  localparam int SEL_FLUSH = 5;
  localparam int SEL_CNT   = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } ExpT;

  logic        aclk;
  logic        aresetn;
  logic        ex_valid;
  logic        ex_fire;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        ex_div;
  logic [4:0]  id_rj;
  logic [4:0]  id_rk;
  logic        ex_br_redirect;
  logic        wb_exc;
  logic        if_ready_go;
  logic        id_ready_go;
  logic        ex_ready_go;
  logic        if_flush;
  logic        id_flush;
  logic        ex_flush;
  logic        mem_flush;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  ExpT expQ[$];
  int  checks = 0;
  int  errors = 0;

  pipe_ctrl #(.DIV_CYCLES(17)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .ex_valid      (ex_valid),
    .ex_fire       (ex_fire),
    .ex_load       (ex_load),
    .ex_rd         (ex_rd),
    .ex_div        (ex_div),
    .id_rj         (id_rj),
    .id_rk         (id_rk),
    .ex_br_redirect(ex_br_redirect),
    .wb_exc        (wb_exc),
    .if_ready_go   (if_ready_go),
    .id_ready_go   (id_ready_go),
    .ex_ready_go   (ex_ready_go),
    .if_flush      (if_flush),
    .id_flush      (id_flush),
    .ex_flush      (ex_flush),
    .mem_flush     (mem_flush),
    .state         (state),
    .stall_cnt     (stall_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_STATE: return 32'(state);
      SEL_STALL: return stall_cnt;
      SEL_IFRDY: return 32'(if_ready_go);
      SEL_IDRDY: return 32'(id_ready_go);
      SEL_EXRDY: return 32'(ex_ready_go);
      SEL_FLUSH: return 32'({if_flush, id_flush, ex_flush, mem_flush});
      SEL_CNT:   return 32'(dut.r_cnt);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic applyStimulus(input logic rstn, input logic valid, input logic fire,
                               input logic load, input logic [4:0] rd, input logic div,
                               input logic [4:0] rj, input logic [4:0] rk,
                               input logic br, input logic exc);
    @(negedge aclk);
    aresetn        = rstn;
    ex_valid       = valid;
    ex_fire        = fire;
    ex_load        = load;
    ex_rd          = rd;
    ex_div         = div;
    id_rj          = rj;
    id_rk          = rk;
    ex_br_redirect = br;
    wb_exc         = exc;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    ExpT e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  // Monitor: everything queued for a cycle is compared once inputs have settled.
  initial begin
    ExpT         e;
    logic [31:0] act;
    forever begin
      @(negedge aclk);
      #2;
      while (expQ.size() > 0) begin
        e   = expQ.pop_front();
        act = pick(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: actual %0h required %0h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetn = 1'b0; ex_valid = 1'b0; ex_fire = 1'b0; ex_load = 1'b0; ex_rd = 5'd0;
    ex_div = 1'b0; id_rj = 5'd0; id_rk = 5'd0; ex_br_redirect = 1'b0; wb_exc = 1'b0;

    // Reset values, including a load-use pattern that must be masked.
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("rst_state", SEL_STATE, 0);
    checkOutput("rst_stall", SEL_STALL, 0);
    checkOutput("rst_flush", SEL_FLUSH, 4'hF);
    checkOutput("rst_cnt",   SEL_CNT,   0);
    checkOutput("rst_ifrdy", SEL_IFRDY, 1);
    applyStimulus(0, 1, 0, 1, 5'd5, 0, 5'd0, 5'd5, 0, 0);
    checkOutput("rst_idrdy_hazard", SEL_IDRDY, 1);
    checkOutput("rst_exrdy", SEL_EXRDY, 1);

    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("run_flush", SEL_FLUSH, 4'h0);
    checkOutput("run_ifrdy", SEL_IFRDY, 1);
    checkOutput("run_stall", SEL_STALL, 0);

    // Load-use interlock.
    applyStimulus(1, 1, 0, 1, 5'd5, 0, 5'd0, 5'd5, 0, 0);
    checkOutput("lu_rk_idrdy", SEL_IDRDY, 0);
    checkOutput("lu_rk_exrdy", SEL_EXRDY, 1);
    checkOutput("lu_stall0", SEL_STALL, 0);
    applyStimulus(1, 1, 0, 1, 5'd5, 0, 5'd0, 5'd5, 0, 0);
    checkOutput("lu_stall1", SEL_STALL, 1);
    applyStimulus(1, 1, 0, 1, 5'd5, 0, 5'd0, 5'd5, 0, 0);
    checkOutput("lu_stall2", SEL_STALL, 2);
    applyStimulus(1, 1, 0, 1, 5'd5, 0, 5'd5, 5'd0, 0, 0);
    checkOutput("lu_rj_idrdy", SEL_IDRDY, 0);
    checkOutput("lu_stall3", SEL_STALL, 3);
    applyStimulus(1, 1, 0, 1, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("lu_r0_idrdy", SEL_IDRDY, 1);
    checkOutput("lu_stall4", SEL_STALL, 4);
    applyStimulus(1, 1, 0, 0, 5'd5, 0, 5'd0, 5'd5, 0, 0);
    checkOutput("noload_idrdy", SEL_IDRDY, 1);
    checkOutput("noload_stall", SEL_STALL, 4);

    // Branch redirect flushes only the front end.
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 1, 0);
    checkOutput("br_flush", SEL_FLUSH, 4'b1100);
    checkOutput("br_stall", SEL_STALL, 4);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("br_off_flush", SEL_FLUSH, 4'h0);
    applyStimulus(1, 1, 0, 1, 5'd7, 0, 5'd7, 5'd0, 1, 0);
    checkOutput("br_lu_flush", SEL_FLUSH, 4'b1100);
    checkOutput("br_lu_idrdy", SEL_IDRDY, 0);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("br_lu_stall", SEL_STALL, 5);

    // Divide: 16 busy cycles, ready on the 17th, then no re-entry until ex_fire.
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("div_d0_state", SEL_STATE, 0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
      checkOutput($sformatf("div_busy_state_%0d", k), SEL_STATE, 1);
      checkOutput($sformatf("div_busy_exrdy_%0d", k), SEL_EXRDY, 0);
      checkOutput($sformatf("div_busy_cnt_%0d", k), SEL_CNT, 32'(17 - k));
    end
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("div_last_state", SEL_STATE, 1);
    checkOutput("div_last_cnt", SEL_CNT, 0);
    checkOutput("div_last_exrdy", SEL_EXRDY, 1);
    checkOutput("div_last_stall", SEL_STALL, 21);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
      checkOutput($sformatf("div_done_state_%0d", k), SEL_STATE, 0);
      checkOutput($sformatf("div_done_exrdy_%0d", k), SEL_EXRDY, 1);
    end
    checkOutput("div_done_stall", SEL_STALL, 21);
    applyStimulus(1, 1, 1, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("div_fire_state", SEL_STATE, 0);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("div2_start_state", SEL_STATE, 0);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("div2_state", SEL_STATE, 1);
    checkOutput("div2_cnt", SEL_CNT, 16);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    end

    // Exception at cnt==9 aborts the divide.
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 1);
    checkOutput("exc_cnt9", SEL_CNT, 9);
    checkOutput("exc_flush", SEL_FLUSH, 4'hF);
    checkOutput("exc_stall", SEL_STALL, 28);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("exc1_state", SEL_STATE, 2);
    checkOutput("exc1_ifrdy", SEL_IFRDY, 0);
    checkOutput("exc1_flush", SEL_FLUSH, 4'h0);
    checkOutput("exc1_cnt", SEL_CNT, 0);
    checkOutput("exc1_stall", SEL_STALL, 28);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 1, 1);
    checkOutput("excbr_state", SEL_STATE, 0);
    checkOutput("excbr_flush", SEL_FLUSH, 4'hF);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
    checkOutput("excexc_state", SEL_STATE, 2);
    checkOutput("excexc_flush", SEL_FLUSH, 4'hF);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("reexc_state", SEL_STATE, 2);
    checkOutput("reexc_ifrdy", SEL_IFRDY, 0);
    checkOutput("reexc_flush", SEL_FLUSH, 4'h0);
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    checkOutput("postexc_state", SEL_STATE, 0);
    checkOutput("postexc_ifrdy", SEL_IFRDY, 1);
    checkOutput("postexc_stall", SEL_STALL, 28);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("rdiv_f0_state", SEL_STATE, 0);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("rdiv_f1_stall", SEL_STALL, 28);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("rdiv_f4_state", SEL_STATE, 1);
    checkOutput("rdiv_f4_stall", SEL_STALL, 31);
    applyStimulus(0, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("arst_state", SEL_STATE, 0);
    checkOutput("arst_stall", SEL_STALL, 0);
    checkOutput("arst_cnt", SEL_CNT, 0);
    checkOutput("arst_flush", SEL_FLUSH, 4'hF);
    checkOutput("arst_exrdy", SEL_EXRDY, 1);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("rel_state", SEL_STATE, 0);
    checkOutput("rel_flush", SEL_FLUSH, 4'h0);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("rel_div_state", SEL_STATE, 1);
    checkOutput("rel_div_cnt", SEL_CNT, 16);
    checkOutput("rel_div_stall", SEL_STALL, 0);

    // Saturation: preload the counter while the divide keeps EX stalled.
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    release dut.r_stall_cnt;
    checkOutput("sat_state", SEL_STATE, 1);
    checkOutput("sat_stall0", SEL_STALL, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("sat_stall1", SEL_STALL, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 0, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    checkOutput("sat_stall2", SEL_STALL, 32'hFFFF_FFFF);

    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    repeat (3) @(negedge aclk);
    #5;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 17: fixed EX-stage occupancy of div/mod, in cycles; legal range 2..255.
REQ-002 SHALL have port aclk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ex_valid  input  1  EX stage holds a valid instruction.
REQ-005 SHALL have port ex_fire  input  1  EX instruction transfers to MEM this cycle.
REQ-006 SHALL have port ex_load  input  1  EX instruction is a load.
REQ-007 SHALL have port ex_rd  input  5  EX destination register.
REQ-008 SHALL have port ex_div  input  1  EX instruction is div/mod.
REQ-009 SHALL have port id_rj  input  5  ID source register 1; 0 means unused.
REQ-010 SHALL have port id_rk  input  5  ID source register 2; 0 means unused.
REQ-011 SHALL have port ex_br_redirect  input  1  branch resolved in EX redirects fetch.
REQ-012 SHALL have port wb_exc  input  1  exception or ertn committing in WB.
REQ-013 SHALL have ports if_ready_go, id_ready_go, ex_ready_go  output  1 each  per-stage ready_go.
REQ-014 SHALL have ports if_flush, id_flush, ex_flush, mem_flush  output  1 each  per-stage flush.
REQ-015 SHALL have port state  output  2  FSM state: RUN=0, DIV=1, EXC=2.
REQ-016 SHALL have port stall_cnt  output  32  stall-cycle performance counter.

Function
REQ-017 SHALL implement FSM RUN/DIV/EXC, 8-bit down-counter cnt, flag div_done.
REQ-018 RUN->DIV SHALL occur when ex_valid && ex_div && !div_done && !wb_exc; cnt loads DIV_CYCLES-1.
REQ-019 In DIV, cnt SHALL decrement each cycle; ex_ready_go=0 while cnt!=0.
REQ-020 DIV->RUN SHALL occur in the cycle after cnt==0, setting div_done=1.
REQ-021 ex_ready_go SHALL be 1 in the cnt==0 cycle and in RUN.
REQ-022 div_done SHALL clear on ex_fire and prevent re-entry for the same instruction.
REQ-023 Result: div occupies EX exactly DIV_CYCLES cycles before ex_ready_go first rises.
REQ-024 id_ready_go SHALL be 0 (combinational) when ex_valid && ex_load && ex_rd!=0 && (ex_rd==id_rj || ex_rd==id_rk); otherwise 1.
REQ-025 ex_br_redirect SHALL assert if_flush and id_flush combinationally in the same cycle.
REQ-026 ex_br_redirect SHALL NOT assert ex_flush or mem_flush.
REQ-027 wb_exc SHALL assert all four flushes combinationally from any state.
REQ-028 wb_exc SHALL force next state EXC, clear cnt and div_done.
REQ-029 EXC SHALL last exactly one cycle: flushes 0, if_ready_go 0; then RUN.
REQ-030 wb_exc in EXC SHALL re-enter EXC.
REQ-031 if_ready_go SHALL be 1 outside EXC.
REQ-032 wb_exc with ex_br_redirect SHALL follow exception behaviour only.
REQ-033 ex_br_redirect with load-use SHALL flush; id_ready_go still reports the hazard.
REQ-034 stall_cnt SHALL increment when (id_ready_go==0 || ex_ready_go==0) && !wb_exc, saturating at 0xFFFFFFFF.

Reset
REQ-035 While aresetn==0: state=RUN, cnt=0, div_done=0, stall_cnt=0.
REQ-036 While aresetn==0: all flush outputs 1, all ready_go outputs 1.
REQ-037 Reset asserted mid-DIV or mid-EXC SHALL abandon the operation immediately, without waiting for a clock edge.
REQ-038 After aresetn deasserts, the first rising edge SHALL evaluate from RUN.

Verification
REQ-039 ex_valid=ex_div=1 held, DIV_CYCLES=17 -> ex_ready_go=0 for 16 cycles, 1 on cycle 17, state DIV->RUN, no re-entry until ex_fire.
REQ-040 ex_load=1, ex_rd=5, id_rk=5 -> id_ready_go=0, stall_cnt +1 per cycle. With id_rj=id_rk=0 and ex_rd=0 -> id_ready_go=1.
REQ-041 ex_br_redirect pulse -> if_flush=id_flush=1, ex_flush=mem_flush=0, same cycle.
REQ-042 wb_exc at DIV cnt=9 -> all flushes 1. Next cycle: state=EXC, if_ready_go=0, cnt=0. Following cycle: RUN.
REQ-043 wb_exc with ex_br_redirect simultaneously -> all four flushes 1, state EXC next.
REQ-044 aresetn low mid-DIV, stall_cnt=100 -> immediately state=RUN, stall_cnt=0, flushes 1.
REQ-045 Preload stall_cnt=0xFFFFFFFF, hold stall -> counter stays 0xFFFFFFFF.
